bf16_mul_pipe: RTL and testbench

BF16_MUL_PIPE -- requirements
Module: bf16_mul_pipe

---
 rtl/bf16_mul_pipe.sv | 167 ++++++++++++++++
 tb/tb_bf16_mul_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_mul_pipe.sv
// Multi-lane bf16 x bf16 multiplier, three register stages, exact fp32 or bf16 RNE output.
// Zero/subnormal inputs flush to zero; one shared advance enable stalls the whole pipe.
module bf16_mul_pipe #(
    parameter int LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_fmt,
    input  logic [16*LANES-1:0]   in_a,
    input  logic [16*LANES-1:0]   in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   out_p,
    output logic [3*LANES-1:0]    out_flags,
    input  logic                  sts_clr,
    output logic [2:0]            sts
);

    localparam logic [1:0] CLS_NUM  = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    // Joint operand class; NaN outranks inf, inf outranks zero.
    function automatic logic [1:0] f_class(input logic [15:0] x, input logic [15:0] y);
        logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
        x_nan  = (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
        y_nan  = (y[14:7] == 8'hFF) && (y[6:0] != 7'd0);
        x_inf  = (x[14:7] == 8'hFF) && (x[6:0] == 7'd0);
        y_inf  = (y[14:7] == 8'hFF) && (y[6:0] == 7'd0);
        x_zero = (x[14:7] == 8'h00);
        y_zero = (y[14:7] == 8'h00);
        if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero))
            f_class = CLS_NAN;
        else if (x_inf || y_inf)
            f_class = CLS_INF;
        else if (x_zero || y_zero)
            f_class = CLS_ZERO;
        else
            f_class = CLS_NUM;
    endfunction

    // Returns {carry, mantissa[6:0]} of the 23-bit fraction rounded to nearest-even.
    function automatic logic [7:0] f_round_bf16(input logic [22:0] man);
        logic rnd;
        rnd = man[15] & (man[16] | (|man[14:0]));
        f_round_bf16 = {1'b0, man[22:16]} + {7'd0, rnd};
    endfunction

    // Normalise, round, saturate and select; returns {flags, result}.
    function automatic logic [34:0] f_saturate(input logic sgn, input logic [1:0] cls,
                                               input logic [15:0] prod,
                                               input logic signed [9:0] esum, input logic fmt);
        logic [22:0]       man;
        logic [7:0]        rnd;
        logic signed [9:0] e;
        logic [31:0]       inf_v, zero_v, nan_v;
        man    = prod[15] ? {prod[14:0], 8'd0} : {prod[13:0], 9'd0};
        rnd    = f_round_bf16(man);
        e      = (fmt && rnd[7]) ? esum + 10'sd1 : esum;
        inf_v  = fmt ? {16'd0, sgn, 8'hFF, 7'd0} : {sgn, 8'hFF, 23'd0};
        zero_v = fmt ? {16'd0, sgn, 15'd0} : {sgn, 31'd0};
        nan_v  = fmt ? 32'h0000_7FC0 : 32'h7FC0_0000;
        case (cls)
            CLS_NAN:  f_saturate = {3'b100, nan_v};
            CLS_INF:  f_saturate = {3'b000, inf_v};
            CLS_ZERO: f_saturate = {3'b000, zero_v};
            default: begin
                if (e >= 10'sd255)
                    f_saturate = {3'b010, inf_v};
                else if (e <= 10'sd0)
                    f_saturate = {3'b001, zero_v};
                else
                    f_saturate = {3'b000, fmt ? {16'd0, sgn, e[7:0], rnd[6:0]}
                                              : {sgn, e[7:0], man}};
            end
        endcase
    endfunction

    logic                en;
    logic                vld_p0, vld_p1, vld_p2;
    logic                fmt_p0, fmt_p1;
    logic                sgn_p0 [LANES];
    logic [7:0]          ea_p0  [LANES];
    logic [7:0]          eb_p0  [LANES];
    logic [7:0]          ma_p0  [LANES];
    logic [7:0]          mb_p0  [LANES];
    logic [1:0]          cls_p0 [LANES];
    logic                sgn_p1 [LANES];
    logic [1:0]          cls_p1 [LANES];
    logic [15:0]         prod_p1[LANES];
    logic signed [9:0]   esum_p1[LANES];
    logic [32*LANES-1:0] p_p2;
    logic [3*LANES-1:0]  flags_p2;
    logic [15:0]         prod_s1[LANES];
    logic signed [9:0]   esum_s1[LANES];
    logic [2:0]          beat_flags;

    assign en        = ~vld_p2 | out_ready;
    assign in_ready  = en;
    assign out_valid = vld_p2;
    assign out_p     = vld_p2 ? p_p2 : '0;
    assign out_flags = vld_p2 ? flags_p2 : '0;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_s1[i] = {8'd0, ma_p0[i]} * {8'd0, mb_p0[i]};
            esum_s1[i] = $signed({2'b00, ea_p0[i]}) + $signed({2'b00, eb_p0[i]})
                         - 10'sd127 + $signed({9'd0, prod_s1[i][15]});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (en) begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            fmt_p0 <= in_fmt;
            fmt_p1 <= fmt_p0;
            for (int i = 0; i < LANES; i++) begin
                // S1: decode and special-case classification
                sgn_p0[i] <= in_a[16*i+15] ^ in_b[16*i+15];
                ea_p0[i]  <= in_a[16*i+7 +: 8];
                eb_p0[i]  <= in_b[16*i+7 +: 8];
                ma_p0[i]  <= {1'b1, in_a[16*i +: 7]};
                mb_p0[i]  <= {1'b1, in_b[16*i +: 7]};
                cls_p0[i] <= f_class(in_a[16*i +: 16], in_b[16*i +: 16]);
                // S2: mantissa product and exponent sum
                sgn_p1[i]  <= sgn_p0[i];
                cls_p1[i]  <= cls_p0[i];
                prod_p1[i] <= prod_s1[i];
                esum_p1[i] <= esum_s1[i];
                // S3: normalise, round, select
                {flags_p2[3*i +: 3], p_p2[32*i +: 32]} <=
                    f_saturate(sgn_p1[i], cls_p1[i], prod_p1[i], esum_p1[i], fmt_p1);
            end
        end
    end

    always_comb begin
        beat_flags = 3'b000;
        for (int i = 0; i < LANES; i++)
            beat_flags = beat_flags | flags_p2[3*i +: 3];
    end

    // A delivered flag wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst)
            sts <= 3'b000;
        else if (vld_p2 && out_ready)
            sts <= (sts_clr ? 3'b000 : sts) | beat_flags;
        else if (sts_clr)
            sts <= 3'b000;
    end

endmodule

// File: tb/tb_bf16_mul_pipe.sv
// Scoreboard bench for bf16_mul_pipe: driver pushes expected beats, monitor pops on delivery.
module tb_bf16_mul_pipe;
    localparam int LANES = 4;
    localparam int PW    = 32 * LANES;
    localparam int FW    = 3 * LANES;
    localparam int AW    = 16 * LANES;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_fmt = 1'b0;
    logic          out_ready = 1'b1;
    logic          sts_clr = 1'b0;
    logic [AW-1:0] in_a = '0;
    logic [AW-1:0] in_b = '0;
    logic          in_ready, out_valid;
    logic [PW-1:0] out_p;
    logic [FW-1:0] out_flags;
    logic [2:0]    sts;

    bf16_mul_pipe #(.LANES(LANES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_flags(out_flags), .sts_clr(sts_clr), .sts(sts)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] p;
        logic [FW-1:0] f;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       mon_en = 1'b0;
    logic [2:0] sts_model = 3'b000;
    int         ready_mode = 0;
    int         clr_mode = 0;
    int         win_cnt = 0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [PW-1:0] p, input logic [FW-1:0] f);
        exp_t r;
        r.p = p;
        r.f = f;
        return r;
    endfunction

    // Reference multiply from the number format rules, integer arithmetic only.
    function automatic logic [34:0] ref_lane(input logic [15:0] a, input logic [15:0] b,
                                             input logic fmt);
        int ea, eb, e, ma, mb, prod, f23, keep, rem;
        logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [31:0] inf_v, zero_v, nan_v, p;
        logic [2:0] fl;
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        s = a[15] ^ b[15];
        a_nan = (ea == 255) && (a[6:0] != 0);
        b_nan = (eb == 255) && (b[6:0] != 0);
        a_inf = (ea == 255) && (a[6:0] == 0);
        b_inf = (eb == 255) && (b[6:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        inf_v  = fmt ? {16'h0, s, 8'hFF, 7'h0} : {s, 8'hFF, 23'h0};
        zero_v = fmt ? {16'h0, s, 15'h0} : {s, 31'h0};
        nan_v  = fmt ? 32'h0000_7FC0 : 32'h7FC0_0000;
        fl = 3'b000;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p = nan_v;
            fl = 3'b100;
        end else if (a_inf || b_inf) begin
            p = inf_v;
        end else if (a_zero || b_zero) begin
            p = zero_v;
        end else begin
            ma = 128 + int'(a[6:0]);
            mb = 128 + int'(b[6:0]);
            prod = ma * mb;
            e = ea + eb - 127;
            if (prod >= 32768) begin
                e = e + 1;
                f23 = (prod - 32768) * 256;
            end else begin
                f23 = (prod - 16384) * 512;
            end
            keep = f23 / 65536;
            rem = f23 % 65536;
            if (fmt) begin
                if (rem > 32768 || (rem == 32768 && (keep % 2) == 1)) keep = keep + 1;
                if (keep == 128) begin
                    keep = 0;
                    e = e + 1;
                end
            end
            if (e >= 255) begin
                p = inf_v;
                fl = 3'b010;
            end else if (e <= 0) begin
                p = zero_v;
                fl = 3'b001;
            end else begin
                p = fmt ? {16'h0, s, 8'(e), 7'(keep)} : {s, 8'(e), 23'(f23)};
            end
        end
        return {fl, p};
    endfunction

    function automatic exp_t ref_beat(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                      input logic fmt);
        exp_t r;
        logic [34:0] l;
        for (int i = 0; i < LANES; i++) begin
            l = ref_lane(a[16*i +: 16], b[16*i +: 16], fmt);
            r.p[32*i +: 32] = l[31:0];
            r.f[3*i +: 3] = l[34:32];
        end
        return r;
    endfunction

    function automatic logic [2:0] or_flags(input logic [FW-1:0] f);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < LANES; i++) r = r | f[3*i +: 3];
        return r;
    endfunction

    function automatic logic [15:0] rand_bf16();
        int k;
        logic [7:0] e;
        logic [6:0] m;
        k = $urandom_range(0, 99);
        m = 7'($urandom);
        if (k < 8) e = 8'h00;
        else if (k < 13) begin e = 8'hFF; m = 7'd0; end
        else if (k < 17) begin e = 8'hFF; m = m | 7'd1; end
        else if (k < 40) e = 8'($urandom_range(1, 254));
        else e = 8'($urandom_range(100, 154));
        return {1'($urandom), e, m};
    endfunction

    function automatic logic [AW-1:0] rand_vec();
        logic [AW-1:0] v;
        for (int i = 0; i < LANES; i++) v[16*i +: 16] = rand_bf16();
        return v;
    endfunction

    task automatic tick(input logic v, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic fmt, input exp_t e, output logic acc);
        @(negedge clk);
        case (ready_mode)
            1: out_ready = ($urandom_range(0, 9) < 7);
            2: begin
                out_ready = !(win_cnt >= 4 && win_cnt <= 7);
                win_cnt++;
            end
            default: out_ready = 1'b1;
        endcase
        sts_clr = (clr_mode == 1) ? ($urandom_range(0, 9) == 0) : 1'b0;
        in_valid = v;
        in_a = a;
        in_b = b;
        in_fmt = fmt;
        #1;
        acc = v && in_ready;
        if (acc) sb.push_back(e);
    endtask

    task automatic idle();
        logic acc;
        tick(1'b0, '0, '0, 1'b0, '0, acc);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic fmt,
                        input exp_t e);
        logic acc;
        int tries;
        tries = 0;
        do begin
            tick(1'b1, a, b, fmt, e, acc);
            tries++;
        end while (!acc && tries < 100);
        n_cmp++;
        if (!acc) begin
            n_bad++;
            $display("FAIL send_accept: in_ready never high in %0d cycles", tries);
        end
    endtask

    task automatic send_ref(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic fmt);
        send(a, b, fmt, ref_beat(a, b, fmt));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            idle();
            n++;
        end
        n_cmp++;
        if (n >= 300) begin
            n_bad++;
            $display("FAIL drain: %0d beats still outstanding after %0d cycles", sb.size(), n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        sts_clr = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: samples mid-low-phase, after the driver has settled its inputs.
    exp_t          mon_e;
    logic          stall = 1'b0;
    logic [PW-1:0] prev_p = '0;
    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            check("sts", PW'(sts), PW'(sts_model));
            if (rst) begin
                sts_model = 3'b000;
                stall = 1'b0;
            end else begin
                if (stall) check("stall_hold_p", out_p, prev_p);
                if (!out_valid) check("idle_flags", PW'(out_flags), '0);
                if (out_valid && !out_ready) check("stall_in_ready", PW'(in_ready), '0);
                if (out_valid && out_ready) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_out: got %h, expected no beat", out_p);
                    end else begin
                        mon_e = sb.pop_front();
                        check("out_p", out_p, mon_e.p);
                        check("out_flags", PW'(out_flags), PW'(mon_e.f));
                        sts_model = (sts_clr ? 3'b000 : sts_model) | or_flags(mon_e.f);
                    end
                end else if (sts_clr) begin
                    sts_model = 3'b000;
                end
                stall = out_valid && !out_ready;
                prev_p = out_p;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [AW-1:0] a, b;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", PW'(out_valid), '0);
        check("rst_out_p", out_p, '0);
        check("rst_out_flags", PW'(out_flags), '0);
        check("rst_sts", PW'(sts), '0);
        check("rst_in_ready", PW'(in_ready), PW'(1));
        mon_en = 1'b1;

        // exact fp32 products and latency
        send({LANES{16'h3F80}}, {LANES{16'h3F80}}, 1'b0, mk({LANES{32'h3F80_0000}}, '0));
        n = 0;
        do begin
            idle();
            n++;
        end while (!out_valid && n < 20);
        check("latency", PW'(n), PW'(3));
        drain();
        send({LANES{16'h3FC0}}, {LANES{16'h3FC0}}, 1'b0, mk({LANES{32'h4010_0000}}, '0));
        // bf16 rounding: below half, and tie with odd LSB
        send({LANES{16'h3F81}}, {LANES{16'h3F81}}, 1'b1, mk({LANES{32'h0000_3F82}}, '0));
        send({LANES{16'h3F81}}, {LANES{16'h3FC0}}, 1'b1, mk({LANES{32'h0000_3FC2}}, '0));
        // specials: lane0 inf*0, lane1 overflow, lane2 underflow, lane3 -inf*1
        send({16'hFF80, 16'h0080, 16'h7F00, 16'h7F80}, {16'h3F80, 16'h0080, 16'h7F00, 16'h0000},
             1'b0, mk({32'hFF80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000},
                      {3'b000, 3'b001, 3'b010, 3'b100}));
        drain();
        check("sts_specials", PW'(sts), PW'(3'b111));

        // backpressure window over a six-beat stream
        ready_mode = 2;
        win_cnt = 0;
        for (int i = 0; i < 6; i++) send_ref(rand_vec(), rand_vec(), 1'($urandom));
        ready_mode = 0;
        drain();

        // random traffic, random backpressure and status clears
        ready_mode = 1;
        clr_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) idle();
            else send_ref(rand_vec(), rand_vec(), 1'($urandom));
        end
        drain();
        ready_mode = 0;
        clr_mode = 0;

        // reset with two beats in flight
        send_ref(rand_vec(), rand_vec(), 1'b0);
        send_ref(rand_vec(), rand_vec(), 1'b1);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle();
            check("post_rst_out_valid", PW'(out_valid), '0);
        end
        check("post_rst_sts", PW'(sts), '0);

        // clear coinciding with a flagged delivery: set wins
        send({LANES{16'h0080}}, {LANES{16'h0080}}, 1'b0, mk('0, {LANES{3'b001}}));
        drain();
        check("sts_underflow", PW'(sts), PW'(3'b001));
        a = {LANES{16'h7F00}};
        b = {LANES{16'h7F00}};
        send(a, b, 1'b0, mk({LANES{32'h7F80_0000}}, {LANES{3'b010}}));
        idle();
        idle();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b0;
        sts_clr = 1'b1;
        #1;
        check("clr_cycle_out_valid", PW'(out_valid), PW'(1));
        idle();
        drain();
        check("sts_set_wins", PW'(sts), PW'(3'b010));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
